// File: rtl/sparc_mem_pkg.sv
// Shared types and constants for the memory access sequencer: FSM state
// encoding, MAR/MDR mux select values and the default fetch opcode.
package sparc_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_MAR = 3'd1,
        ST_LOAD_MDR = 3'd2,
        ST_WAIT     = 3'd3,
        ST_CAPTURE  = 3'd4,
        ST_FAULT    = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    localparam logic MAR_SEL_PC  = 1'b0;
    localparam logic MAR_SEL_ALU = 1'b1;
    localparam logic MDR_SEL_BUS = 1'b0;
    localparam logic MDR_SEL_RAM = 1'b1;

    // Word load used for every instruction fetch.
    localparam logic [5:0] FETCH_OPCODE_DEFAULT = 6'b000000;

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Requester, RAM handshake and datapath control signals of the sequencer.
// Handshake: a requester raises its req and holds it until its ack pulses for
// one cycle; MFC from the RAM is only honoured while the strobe is in WAIT.
interface mem_access_sequencer_if;

    logic       if_req;
    logic       if_ack;
    logic       d_req;
    logic       d_write;
    logic [5:0] d_opcode;
    logic       d_ack;
    logic       err;
    logic       MFC;
    logic       MAR_Enable;
    logic       MAR_Mux_select;
    logic       MDR_Enable;
    logic       MDR_Mux_select;
    logic       RAM_enable;
    logic [5:0] RAM_OpCode;
    logic       busy;

    // Environment side: ControlUnit requesters and the RAM's MFC line.
    modport master (
        output if_req, d_req, d_write, d_opcode, MFC,
        input  if_ack, d_ack, err, MAR_Enable, MAR_Mux_select, MDR_Enable,
               MDR_Mux_select, RAM_enable, RAM_OpCode, busy
    );

    modport slave (
        input  if_req, d_req, d_write, d_opcode, MFC,
        output if_ack, d_ack, err, MAR_Enable, MAR_Mux_select, MDR_Enable,
               MDR_Mux_select, RAM_enable, RAM_OpCode, busy
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts WAIT cycles and flags the cycle on which the count would reach
// TIMEOUT_CYCLES; a TIMEOUT_CYCLES of 0 never times out.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic incr,
    output logic timed_out
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Compare against the pre-increment value so the fault follows the Nth cycle.
    localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (incr) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timed_out = (TIMEOUT_CYCLES != 0) && incr && (count_q == LIMIT);

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences MAR/MDR/RAM controls for one memory transaction at a time,
// arbitrating fetch vs data requests (data wins) and acking the owner.
module mem_access_sequencer
    import sparc_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [5:0]  FETCH_OPCODE   = FETCH_OPCODE_DEFAULT
) (
    input  logic                  Clk,
    input  logic                  Clr,
    mem_access_sequencer_if.slave bus,
    output state_e                dbg_state
);

    state_e     state_q, state_d;
    logic       owner_q, owner_d;      // 1 = data side, 0 = fetch side
    logic       write_q, write_d;
    logic [5:0] opcode_q, opcode_d;
    logic       err_flag_q, err_flag_d;

    logic timer_clear;
    logic timer_incr;
    logic timed_out;

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (Clk),
        .rst      (Clr),
        .clear    (timer_clear),
        .incr     (timer_incr),
        .timed_out(timed_out)
    );

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            write_q    <= 1'b0;
            opcode_q   <= 6'b000000;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            write_q    <= write_d;
            opcode_q   <= opcode_d;
            err_flag_q <= err_flag_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        write_d     = write_q;
        opcode_d    = opcode_q;
        err_flag_d  = err_flag_q;
        timer_clear = 1'b0;
        timer_incr  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.d_req) begin
                    owner_d  = 1'b1;
                    write_d  = bus.d_write;
                    opcode_d = bus.d_opcode;
                    state_d  = ST_LOAD_MAR;
                end else if (bus.if_req) begin
                    owner_d  = 1'b0;
                    write_d  = 1'b0;
                    opcode_d = FETCH_OPCODE;
                    state_d  = ST_LOAD_MAR;
                end
            end
            ST_LOAD_MAR: state_d = write_q ? ST_LOAD_MDR : ST_WAIT;
            ST_LOAD_MDR: state_d = ST_WAIT;
            ST_WAIT: begin
                timer_incr = 1'b1;
                // MFC wins over a timeout reached on the same cycle.
                if (bus.MFC) begin
                    state_d = write_q ? ST_DONE : ST_CAPTURE;
                end else if (timed_out) begin
                    state_d = ST_FAULT;
                end
            end
            ST_CAPTURE: state_d = ST_DONE;
            ST_FAULT: begin
                err_flag_d = 1'b1;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                timer_clear = 1'b1;
                err_flag_d  = 1'b0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs: decoded only from registered state.
    assign bus.MAR_Enable     = (state_q == ST_LOAD_MAR);
    assign bus.MAR_Mux_select = (state_q == ST_LOAD_MAR) ? (owner_q ? MAR_SEL_ALU : MAR_SEL_PC)
                                                         : MAR_SEL_PC;
    assign bus.MDR_Enable     = (state_q == ST_LOAD_MDR) || (state_q == ST_CAPTURE);
    assign bus.MDR_Mux_select = (state_q == ST_CAPTURE) ? MDR_SEL_RAM : MDR_SEL_BUS;
    assign bus.RAM_enable     = (state_q == ST_WAIT) || (state_q == ST_CAPTURE);
    assign bus.RAM_OpCode     = opcode_q;
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.if_ack         = (state_q == ST_DONE) && !owner_q;
    assign bus.d_ack          = (state_q == ST_DONE) && owner_q;
    assign bus.err            = (state_q == ST_DONE) && err_flag_q;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: hand-timed transactions, an ack
// order scoreboard and per-cycle ack/err sanity checks.
module tb_mem_access_sequencer;
    import sparc_mem_pkg::*;

    logic   Clk = 1'b0;
    logic   Clr;
    state_e dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Expected ack order: 1 = fetch (if_ack), 2 = data (d_ack).
    logic [1:0] exp_q[$];

    int   lat;
    logic got_if, got_d, got_err;

    mem_access_sequencer_if bus();

    mem_access_sequencer #(
        .TIMEOUT_CYCLES(16),
        .FETCH_OPCODE  (FETCH_OPCODE_DEFAULT)
    ) dut (
        .Clk      (Clk),
        .Clr      (Clr),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_ack(input int budget, output int cycles, output logic a_if,
                            output logic a_d, output logic a_err);
        cycles = 0;
        a_if   = 1'b0;
        a_d    = 1'b0;
        a_err  = 1'b0;
        while (cycles < budget && !(a_if || a_d)) begin
            step();
            cycles++;
            a_if  = bus.if_ack;
            a_d   = bus.d_ack;
            a_err = bus.err;
        end
        if (!(a_if || a_d)) check("ack_bound", 32'(cycles), 32'(budget + 1));
    endtask

    // Ack scoreboard plus exclusivity and err-only-with-ack checks every cycle.
    always @(negedge Clk) begin
        if (Clr !== 1'b1) begin
            if (bus.if_ack || bus.d_ack) begin
                check("ack_excl", 32'(bus.if_ack & bus.d_ack), 32'(0));
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", 32'({bus.d_ack, bus.if_ack}), 32'(0));
                end else begin
                    check("ack_owner", 32'({bus.d_ack, bus.if_ack}), 32'(exp_q.pop_front()));
                end
            end else begin
                check("err_no_ack", 32'(bus.err), 32'(0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.if_req   = 1'b0;
        bus.d_req    = 1'b0;
        bus.d_write  = 1'b0;
        bus.d_opcode = 6'b000000;
        bus.MFC      = 1'b0;
        Clr          = 1'b1;
        step();
        step();

        // Reset state
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_ram_en", 32'(bus.RAM_enable), 32'(0));
        check("rst_opcode", 32'(bus.RAM_OpCode), 32'(0));
        check("rst_mar_en", 32'(bus.MAR_Enable), 32'(0));
        check("rst_mdr_en", 32'(bus.MDR_Enable), 32'(0));
        Clr = 1'b0;
        step();
        check("idle_stays", 32'(bus.busy), 32'(0));

        // Fetch read, MFC on first WAIT cycle: ack 4 cycles after grant
        bus.if_req = 1'b1;
        exp_q.push_back(2'd1);
        step();
        check("t1_c1_mar_en", 32'(bus.MAR_Enable), 32'(1));
        check("t1_c1_mar_sel", 32'(bus.MAR_Mux_select), 32'(MAR_SEL_PC));
        check("t1_c1_ram_en", 32'(bus.RAM_enable), 32'(0));
        step();
        check("t1_c2_ram_en", 32'(bus.RAM_enable), 32'(1));
        check("t1_c2_opcode", 32'(bus.RAM_OpCode), 32'(FETCH_OPCODE_DEFAULT));
        bus.MFC = 1'b1;
        step();
        bus.MFC = 1'b0;
        check("t1_c3_ram_en", 32'(bus.RAM_enable), 32'(1));
        check("t1_c3_mdr_en", 32'(bus.MDR_Enable), 32'(1));
        check("t1_c3_mdr_sel", 32'(bus.MDR_Mux_select), 32'(MDR_SEL_RAM));
        step();
        check("t1_c4_if_ack", 32'(bus.if_ack), 32'(1));
        check("t1_c4_err", 32'(bus.err), 32'(0));
        check("t1_c4_d_ack", 32'(bus.d_ack), 32'(0));
        bus.if_req = 1'b0;
        step();
        check("t1_c5_busy", 32'(bus.busy), 32'(0));
        check("t1_c5_if_ack", 32'(bus.if_ack), 32'(0));

        // Store with opcode 000100, MFC on the 4th WAIT cycle: DONE at grant+7
        bus.d_req    = 1'b1;
        bus.d_write  = 1'b1;
        bus.d_opcode = 6'b000100;
        exp_q.push_back(2'd2);
        step();
        check("t2_c1_mar_en", 32'(bus.MAR_Enable), 32'(1));
        check("t2_c1_mar_sel", 32'(bus.MAR_Mux_select), 32'(MAR_SEL_ALU));
        bus.d_write  = 1'b0;
        bus.d_opcode = 6'b111111;
        step();
        check("t2_c2_state", 32'(dbg_state), 32'(ST_LOAD_MDR));
        check("t2_c2_mdr_en", 32'(bus.MDR_Enable), 32'(1));
        check("t2_c2_mdr_sel", 32'(bus.MDR_Mux_select), 32'(MDR_SEL_BUS));
        check("t2_c2_ram_en", 32'(bus.RAM_enable), 32'(0));
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_wait_ram_en", 32'(bus.RAM_enable), 32'(1));
            check("t2_wait_opcode", 32'(bus.RAM_OpCode), 32'(6'b000100));
            check("t2_wait_mdr_en", 32'(bus.MDR_Enable), 32'(0));
            if (i == 3) bus.MFC = 1'b1;
        end
        step();
        bus.MFC = 1'b0;
        check("t2_c7_d_ack", 32'(bus.d_ack), 32'(1));
        check("t2_c7_err", 32'(bus.err), 32'(0));
        check("t2_c7_mdr_en", 32'(bus.MDR_Enable), 32'(0));
        check("t2_c7_ram_en", 32'(bus.RAM_enable), 32'(0));
        bus.d_req = 1'b0;
        step();
        check("t2_c8_busy", 32'(bus.busy), 32'(0));
        check("t2_c8_opcode_hold", 32'(bus.RAM_OpCode), 32'(6'b000100));

        // Simultaneous requests: data first, one IDLE gap, then fetch
        bus.MFC      = 1'b1;
        bus.if_req   = 1'b1;
        bus.d_req    = 1'b1;
        bus.d_write  = 1'b0;
        bus.d_opcode = 6'b000010;
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd1);
        step();
        check("t3_data_mar_sel", 32'(bus.MAR_Mux_select), 32'(MAR_SEL_ALU));
        wait_ack(16, lat, got_if, got_d, got_err);
        check("t3_d_lat", 32'(lat), 32'(3));
        check("t3_d_first", 32'(got_d), 32'(1));
        bus.d_req = 1'b0;
        step();
        check("t3_gap_busy", 32'(bus.busy), 32'(0));
        step();
        check("t3_fetch_mar_sel", 32'(bus.MAR_Mux_select), 32'(MAR_SEL_PC));
        check("t3_fetch_opcode", 32'(bus.RAM_OpCode), 32'(FETCH_OPCODE_DEFAULT));
        wait_ack(16, lat, got_if, got_d, got_err);
        check("t3_if_lat", 32'(lat), 32'(3));
        check("t3_if_second", 32'(got_if), 32'(1));
        bus.if_req = 1'b0;
        bus.MFC    = 1'b0;
        step();

        // Timeout: 16 WAIT cycles, FAULT, then ack with err; req dropped early
        bus.if_req = 1'b1;
        exp_q.push_back(2'd1);
        step();
        bus.if_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            check("t4_wait_state", 32'(dbg_state), 32'(ST_WAIT));
        end
        step();
        check("t4_fault_state", 32'(dbg_state), 32'(ST_FAULT));
        check("t4_fault_ram_en", 32'(bus.RAM_enable), 32'(0));
        check("t4_fault_busy", 32'(bus.busy), 32'(1));
        step();
        check("t4_done_if_ack", 32'(bus.if_ack), 32'(1));
        check("t4_done_err", 32'(bus.err), 32'(1));
        check("t4_done_ram_en", 32'(bus.RAM_enable), 32'(0));
        step();
        check("t4_after_err", 32'(bus.err), 32'(0));
        check("t4_after_busy", 32'(bus.busy), 32'(0));

        // Clr during WAIT aborts with no ack and clears everything
        bus.d_req    = 1'b1;
        bus.d_write  = 1'b0;
        bus.d_opcode = 6'b001011;
        step();
        step();
        check("t5_wait_ram_en", 32'(bus.RAM_enable), 32'(1));
        check("t5_wait_opcode", 32'(bus.RAM_OpCode), 32'(6'b001011));
        Clr       = 1'b1;
        bus.d_req = 1'b0;
        step();
        Clr = 1'b0;
        check("t5_clr_busy", 32'(bus.busy), 32'(0));
        check("t5_clr_ram_en", 32'(bus.RAM_enable), 32'(0));
        check("t5_clr_opcode", 32'(bus.RAM_OpCode), 32'(0));
        check("t5_clr_mar_en", 32'(bus.MAR_Enable), 32'(0));
        check("t5_clr_mdr_en", 32'(bus.MDR_Enable), 32'(0));
        check("t5_clr_state", 32'(dbg_state), 32'(ST_IDLE));
        for (int i = 0; i < 4; i++) step();

        // Fresh fetch; MFC lands on the 16th WAIT cycle and beats the timeout
        bus.if_req = 1'b1;
        exp_q.push_back(2'd1);
        step();
        for (int i = 0; i < 16; i++) begin
            step();
            check("t5_wait_state", 32'(dbg_state), 32'(ST_WAIT));
            if (i == 15) bus.MFC = 1'b1;
        end
        step();
        bus.MFC = 1'b0;
        check("t5_mfc_wins", 32'(dbg_state), 32'(ST_CAPTURE));
        step();
        check("t5_if_ack", 32'(bus.if_ack), 32'(1));
        check("t5_err", 32'(bus.err), 32'(0));
        bus.if_req = 1'b0;
        step();

        // MFC in IDLE and LOAD_MAR is ignored
        bus.MFC = 1'b1;
        step();
        check("t6_idle_mfc", 32'(bus.busy), 32'(0));
        bus.if_req = 1'b1;
        exp_q.push_back(2'd1);
        step();
        check("t6_load_mar", 32'(dbg_state), 32'(ST_LOAD_MAR));
        bus.MFC    = 1'b0;
        bus.if_req = 1'b0;
        step();
        check("t6_wait1", 32'(dbg_state), 32'(ST_WAIT));
        step();
        check("t6_wait2", 32'(dbg_state), 32'(ST_WAIT));
        bus.MFC = 1'b1;
        step();
        bus.MFC = 1'b0;
        check("t6_capture", 32'(dbg_state), 32'(ST_CAPTURE));
        step();
        check("t6_if_ack", 32'(bus.if_ack), 32'(1));
        step();
        step();

        check("sb_empty", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
